fetch_pc_sequencer: RTL
=======================

Name: fetch_pc_sequencer

Overview:
- Owns the fetch-stage PC register and sequences instruction fetch over a variable-latency instruction-memory request/ack handshake.
- Resolves the D-stage control transfers (beq, jal, jr, bioal) into a next-PC, honouring the one-instruction branch delay slot.
- Buffers a resolved target when the delay slot has not yet been fetched.
- Sits between the hazard unit (stall_d), the D-stage decode/compare logic, instruction memory, and the F/D pipeline register.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- stall_d  in  1  hazard unit freezes F and D stages.
- d_valid  in  1  D stage holds a real instruction (0 = bubble).
- npc_op  in  3  D-stage control op: 0 PC4, 1 BEQ, 2 JAL, 3 JR, 4 BIOAL; 5-7 treated as PC4.
- zero  in  1  D-stage beq compare result.
- overflow  in  1  D-stage bioal overflow condition.
- imm26  in  26  D-stage instruction immediate field.
- ra  in  32  D-stage forwarded rs value for jr.
- pc_d  in  32  PC of the D-stage instruction.
- imem_req  out  1  fetch request; held until ack.
- imem_addr  out  32  fetch address (= pc_f); stable while imem_req=1.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- pc_f  out  32  current fetch PC.
- instr_f  out  32  buffered fetched instruction.
- f_valid  out  1  instr_f valid for F/D transfer.
- fd_en  out  1  F/D register load enable (= f_valid & ~stall_d).
- redir_pending  out  1  debug: a resolved target is waiting for its delay slot.

Behaviour:
- FSM with two states:
  - FETCH: imem_req=1, f_valid=0.
  - VALID: imem_req=0, f_valid=1.
- Reset (reset_n=0 at an edge):
  - state<=FETCH, pc_f<=RESET_PC, instr_f<=0, redir_pending<=0, redir_target<=0.
  - The first request is issued in the cycle after reset is released.
  - An ack belonging to a fetch interrupted by reset is ignored. Memory abandons its request on reset.
- FETCH & imem_ack: instr_f<=imem_rdata, state<=VALID. Request-to-f_valid latency is ack cycle + 1.
- FETCH & ~imem_ack: hold state; pc_f and imem_addr are unchanged.
- An imem_ack seen in VALID is ignored.
- VALID & stall_d: hold everything; instr_f is stable.
- VALID & ~stall_d (accept, fd_en=1): state<=FETCH; pc_f<=next_pc.
- A resolution event occurs when d_valid & ~stall_d.
- taken is computed at the resolution event:
  - JAL, JR: always taken.
  - BEQ: taken when zero=1.
  - BIOAL: taken when overflow=1.
  - PC4/other: never taken.
- Target arithmetic (mod 2^32; no alignment check; jr passes ra through unchanged):
  - BEQ/BIOAL: pc_d + 4 + (sext(imm26[15:0]) << 2).
  - JAL: {pc_d[31:28], imm26, 2'b00}.
  - JR: ra.
- next_pc on accept, in priority order:
  1. If resolution is taken in the same cycle: resolved target. The instruction being accepted is the delay slot.
  2. Else if redir_pending: redir_target. Clear redir_pending in the same cycle.
  3. Else: pc_f + 4.
- Taken resolution without a simultaneous accept (delay slot still in FETCH): redir_pending<=1, redir_target<=target.
- A new taken resolution while redir_pending=1 overwrites the target. This is unreachable for legal code.
- Not-taken resolution: no effect on PC sequencing.
- A resolution while stall_d=1 is not an event; it is re-evaluated when the stall drops.
- Reset has priority over every other event, including a pending redirect.

Test Plan:
1. Reset, ack every cycle-after-req, stall_d=0, d_valid=0 -> imem_addr sequence 0x3000, 0x3004, 0x3008; fd_en pulses once per fetch; f_valid=0 in FETCH.
2. State VALID at pc_f=0x3008, BEQ in D with pc_d=0x3004, imm=0x0003, zero=1, stall_d=0 -> next imem_addr=0x3014; redir_pending stays 0.
3. JAL at pc_d=0x3004, imm26=0x0000C10, resolved while delay-slot fetch at 0x3008 awaits ack -> redir_pending=1. Ack arrives 3 cycles later and the slot is accepted -> next imem_addr=0x0000_3040; redir_pending=0.
4. VALID with stall_d=1 for 4 cycles and JR (ra=0x3100) in D -> pc_f/instr_f frozen, no redirect captured. On release, next imem_addr=0x3100.
5. BIOAL with overflow=0 -> sequential 0x300C. Repeat with overflow=1, imm=0xFFFF -> target pc_d+4-4 = pc_d.
6. reset_n=0 mid-FETCH with redir_pending=1 -> pc_f=0x3000, redir_pending=0. A late imem_ack for the old request, arriving while reset_n=0, is ignored: no instr_f load. The first post-reset imem_addr is 0x3000.

Source files
------------

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC sequencer.
// Owns the fetch PC and fetches over a variable-latency imem request/ack
// handshake. Resolves D-stage control transfers (beq, jal, jr, bioal) into
// the next PC, honouring a one-instruction branch delay slot. A target that
// resolves before its delay slot has been fetched is held until the slot is
// accepted.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   stall_d                  hazard freeze of F and D stages
//   d_valid, npc_op, zero,   D-stage control-transfer inputs
//   overflow, imm26, ra, pc_d
//   imem_req, imem_addr      fetch request / address (address = pc_f)
//   imem_ack, imem_rdata     one-cycle ack with instruction word
//   pc_f, instr_f, f_valid   fetch PC, buffered instruction, buffer valid
//   fd_en                    F/D pipeline register load enable
//   redir_pending            a resolved target waits for its delay slot
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_d,
  input  logic        d_valid,
  input  logic [2:0]  npc_op,
  input  logic        zero,
  input  logic        overflow,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  input  logic [31:0] pc_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_f,
  output logic        f_valid,
  output logic        fd_en,
  output logic        redir_pending
);

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] OP_BEQ   = 3'd1;
  localparam logic [2:0] OP_JAL   = 3'd2;
  localparam logic [2:0] OP_JR    = 3'd3;
  localparam logic [2:0] OP_BIOAL = 3'd4;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [XLEN-1:0]   redir_target;
  logic [XLEN-1:0]   br_off;
  logic [XLEN-1:0]   br_target;
  logic [XLEN-1:0]   jal_target;
  logic [XLEN-1:0]   target;
  logic              taken;
  logic              res_taken;
  logic              accept;

  // Control-transfer target and taken decision for the D-stage instruction
  assign br_off     = {{14{imm26[15]}}, imm26[15:0], 2'b00};
  assign br_target  = pc_d + XLEN'(4) + br_off;
  assign jal_target = {pc_d[31:28], imm26, 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = br_target;
    case (npc_op)
      OP_BEQ:   taken = zero;
      OP_JAL: begin
        taken  = 1'b1;
        target = jal_target;
      end
      OP_JR: begin
        taken  = 1'b1;
        target = ra;
      end
      OP_BIOAL: taken = overflow;
      default:  taken = 1'b0;
    endcase
  end

  // A resolution only counts when D is not frozen
  assign res_taken = d_valid & ~stall_d & taken;
  assign accept    = (state == S_VALID) & ~stall_d;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (imem_ack) state_nxt = S_VALID;
      S_VALID: if (!stall_d) state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req = 1'b0;
    f_valid  = 1'b0;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_VALID: f_valid  = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = pc_f;
  assign fd_en     = f_valid & ~stall_d;

  // PC, instruction buffer and delayed-redirect bookkeeping
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_f          <= RESET_PC;
      instr_f       <= '0;
      redir_pending <= 1'b0;
      redir_target  <= '0;
    end else begin
      if ((state == S_FETCH) && imem_ack) instr_f <= imem_rdata;
      if (accept) begin
        // A same-cycle taken resolution means the accepted word is its delay slot
        if (res_taken)          pc_f <= target;
        else if (redir_pending) pc_f <= redir_target;
        else                    pc_f <= pc_f + XLEN'(4);
        redir_pending <= 1'b0;
      end else if (res_taken) begin
        // Delay slot not yet fetched: remember where to go after it
        redir_pending <= 1'b1;
        redir_target  <= target;
      end
    end
  end

endmodule
